// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, next-PC select encoding, fetch FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Next-PC select as produced by the decoder; codes 1, 6 and 7 fall back to SEQ.
  typedef enum logic [2:0] {
    SEQ  = 3'd0,
    JR   = 3'd2,
    JUMP = 3'd3,
    BNE  = 3'd4,
    BEQ  = 3'd5
  } pcsrc_t;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALTED
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Instruction addresses are always word-aligned; low bits are simply dropped.
  function automatic word_t align_word(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch unit.
module next_pc_calc
  import cpu_types_pkg::*;
(
  input  word_t       pc_plus4,
  input  logic [2:0]  pcsrc,
  input  logic        zero,
  input  word_t       branch_addr,
  input  logic [25:0] jaddr,
  input  word_t       rsdata,
  output word_t       next_pc
);

  word_t branch_tgt;
  word_t sel;

  assign branch_tgt = pc_plus4 + branch_addr;

  // Pick the raw target; unknown select codes behave as sequential.
  always_comb begin
    sel = pc_plus4;
    case (pcsrc_t'(pcsrc))
      SEQ:     sel = pc_plus4;
      JR:      sel = rsdata;
      JUMP:    sel = {pc_plus4[31:28], jaddr, 2'b00};
      BNE:     sel = zero ? pc_plus4 : branch_tgt;
      BEQ:     sel = zero ? branch_tgt : pc_plus4;
      default: sel = pc_plus4;
    endcase
  end

  // A misaligned JR target is truncated rather than trapped.
  assign next_pc = align_word(sel);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one read at a time, holds the
// fetched word until the decoder accepts it, and stops for good on HALT.
module instr_fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output word_t       iaddr,
  input  logic        iwait,
  input  word_t       iload,
  output word_t       imemload,
  output logic        ivalid,
  input  logic        dready,
  input  logic [2:0]  PCsrc,
  input  logic        halt,
  input  logic        zero,
  input  word_t       BranchAddr,
  input  logic [25:0] jaddr,
  input  word_t       rsdata,
  output word_t       pc,
  output word_t       pc_plus4,
  output logic        halted
);

  fetch_state_t state, state_nx;
  word_t        next_pc;
  logic         fetch_done;
  logic         accept;

  next_pc_calc u_next_pc (
    .pc_plus4    (pc_plus4),
    .pcsrc       (PCsrc),
    .zero        (zero),
    .branch_addr (BranchAddr),
    .jaddr       (jaddr),
    .rsdata      (rsdata),
    .next_pc     (next_pc)
  );

  assign pc_plus4 = pc + PC_STEP;
  assign iaddr    = pc;
  assign iREN     = (state == FETCH) && !RST;
  assign ivalid   = (state == HOLD) && !RST;
  assign halted   = (state == HALTED);

  // State register; reset wins over every in-flight event.
  always_ff @(posedge CLK) begin
    if (RST) state <= FETCH;
    else     state <= state_nx;
  end

  // Next-state logic: fetch completes on !iwait, HOLD leaves on decoder accept.
  always_comb begin
    state_nx   = state;
    fetch_done = 1'b0;
    accept     = 1'b0;
    case (state)
      FETCH: begin
        if (!iwait) begin
          fetch_done = 1'b1;
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        if (dready) begin
          accept   = 1'b1;
          state_nx = halt ? HALTED : FETCH;
        end
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = FETCH;
    endcase
  end

  // Datapath: latch the fetched word, advance PC on a non-HALT accept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc       <= PC_INIT;
      imemload <= '0;
    end else begin
      if (fetch_done)        imemload <= iload;
      if (accept && !halt)   pc       <= next_pc;
    end
  end

endmodule
